// File: rtl/hermes_rx_buffer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | hermes_rx_buffer: Hermes router input buffer with credit flow control, |
// | route request and size-tracked packet forwarding.  Revision: 1.0       |
// +-----------------------------------------------------------------------+
module hermes_rx_buffer #(
  parameter int FLIT_SIZE   = 32,
  parameter int BUFFER_SIZE = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rx_i,
  input  logic [FLIT_SIZE-1:0] data_i,
  output logic                 credit_o,
  output logic                 req_o,
  input  logic                 ack_h_i,
  output logic                 data_av_o,
  output logic [FLIT_SIZE-1:0] data_o,
  input  logic                 data_ack_i,
  output logic                 sending_o
);

  localparam int ADDR_W = $clog2(BUFFER_SIZE);
  localparam int CNT_W  = ADDR_W + 1;
  localparam logic [CNT_W-1:0]     C_DEPTH = CNT_W'(BUFFER_SIZE);
  localparam logic [FLIT_SIZE-1:0] C_ONE   = FLIT_SIZE'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_SEND = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    P_HDR     = 2'd0,
    P_SIZE    = 2'd1,
    P_PAYLOAD = 2'd2
  } phase_t;

  logic [FLIT_SIZE-1:0] mem [BUFFER_SIZE];

  logic [ADDR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  state_t               state_q, state_d;
  phase_t               phase_q, phase_d;
  logic [FLIT_SIZE-1:0] remaining_q, remaining_d;

  logic not_empty;
  logic wr_en;
  logic rd_en;
  logic last_flit;

  // Credit is withheld while reset is asserted so nothing is written during it.
  assign not_empty = (count_q != '0);
  assign credit_o  = (count_q < C_DEPTH) && !rst_i;
  assign data_o    = mem[rd_ptr_q];
  assign req_o     = (state_q == S_REQ);
  assign sending_o = (state_q == S_SEND);
  assign data_av_o = (state_q == S_SEND) && not_empty;
  assign wr_en     = rx_i && credit_o;
  assign rd_en     = data_av_o && data_ack_i;

  always_comb begin
    last_flit = 1'b0;
    if (rd_en) begin
      case (phase_q)
        P_SIZE:    last_flit = (data_o == '0);
        P_PAYLOAD: last_flit = (remaining_q == C_ONE);
        default:   last_flit = 1'b0;
      endcase
    end
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    state_d     = state_q;
    phase_d     = phase_q;
    remaining_d = remaining_q;

    if (wr_en) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + ADDR_W'(1);

    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      S_IDLE:  if (not_empty) state_d = S_REQ;
      S_REQ:   if (ack_h_i) state_d = S_SEND;
      S_SEND:  if (last_flit) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Size flit loads the payload counter; the last read rearms for a header.
    if (rd_en) begin
      case (phase_q)
        P_HDR: phase_d = P_SIZE;
        P_SIZE: begin
          remaining_d = data_o;
          phase_d     = P_PAYLOAD;
        end
        P_PAYLOAD: remaining_d = remaining_q - C_ONE;
        default:   phase_d = P_HDR;
      endcase
      if (last_flit) phase_d = P_HDR;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= S_IDLE;
      phase_q     <= P_HDR;
      remaining_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      phase_q     <= phase_d;
      remaining_q <= remaining_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr_q] <= data_i;
  end

endmodule
`default_nettype wire

// File: tb/tb_hermes_rx_buffer.sv
`default_nettype none
// tb_hermes_rx_buffer: directed and randomized packets checked against a
// packet-level model of the buffer (flit queue + connection/parse state).
module tb_hermes_rx_buffer;

  localparam int FW    = 32;
  localparam int DEPTH = 8;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          rx_i;
  logic [FW-1:0] data_i;
  logic          credit_o;
  logic          req_o;
  logic          ack_h_i;
  logic          data_av_o;
  logic [FW-1:0] data_o;
  logic          data_ack_i;
  logic          sending_o;

  int checks = 0;
  int errors = 0;

  hermes_rx_buffer #(.FLIT_SIZE(FW), .BUFFER_SIZE(DEPTH)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rx_i       (rx_i),
    .data_i     (data_i),
    .credit_o   (credit_o),
    .req_o      (req_o),
    .ack_h_i    (ack_h_i),
    .data_av_o  (data_av_o),
    .data_o     (data_o),
    .data_ack_i (data_ack_i),
    .sending_o  (sending_o)
  );

  always #5 clk_i = ~clk_i;

  // Stimulus controls
  logic [FW-1:0] tx_q[$];
  bit tx_force = 0, tx_hold = 0, ack_low = 0, h_noise = 0, auto_h = 1;
  int tx_pct = 100, h_pct = 100, d_pct = 100, ack_once = 0;

  // Model state
  logic [FW-1:0] mq[$];
  logic [FW-1:0] rd_log[$];
  bit m_open = 0, p_open = 0, p_req = 0;
  int p_cnt = 0, idx = 0;
  logic [FW-1:0] rem = '0;
  int handshakes = 0, pkts_done = 0, req_seen = 0, accepted = 0;

  // Input driver: all DUT inputs change 1 time unit after the rising edge.
  initial begin
    rx_i = 0; data_i = '0; ack_h_i = 0; data_ack_i = 0;
    forever begin
      @(posedge clk_i); #1;
      if (tx_q.size() != 0 && !tx_hold && (tx_force || credit_o) &&
          int'($urandom_range(99)) < tx_pct) begin
        rx_i = 1; data_i = tx_q.pop_front();
      end else begin
        rx_i = 0; data_i = $urandom;
      end
      if (req_o) ack_h_i = auto_h && (int'($urandom_range(99)) < h_pct);
      else       ack_h_i = h_noise && ($urandom_range(3) == 0);
      if (ack_once > 0 && data_av_o) begin
        data_ack_i = 1; ack_once--;
      end else begin
        data_ack_i = !ack_low && (int'($urandom_range(99)) < d_pct);
      end
    end
  end

  // Monitor/scoreboard at the falling edge: predicts outputs, then applies
  // the effect of the coming rising edge to the model.
  always @(negedge clk_i) begin : monitor
    bit e_credit, e_av, e_req, rd, last;
    int cnt;
    logic [FW-1:0] flit;
    if (rst_i) begin
      checks++;
      if (credit_o !== 1'b0) begin
        errors++; $display("FAIL credit_during_reset: got %b want 0", credit_o);
      end
      mq.delete(); m_open = 0; p_open = 0; p_req = 0; p_cnt = 0; idx = 0; rem = '0;
    end else begin
      cnt      = mq.size();
      e_credit = cnt < DEPTH;
      e_av     = m_open && cnt != 0;
      e_req    = !m_open && (p_req || (!p_open && p_cnt != 0));
      checks += 4;
      if (credit_o !== e_credit) begin
        errors++; $display("FAIL credit: got %b want %b (t=%0t)", credit_o, e_credit, $time);
      end
      if (sending_o !== m_open) begin
        errors++; $display("FAIL sending: got %b want %b (t=%0t)", sending_o, m_open, $time);
      end
      if (data_av_o !== e_av) begin
        errors++; $display("FAIL data_av: got %b want %b (t=%0t)", data_av_o, e_av, $time);
      end
      if (req_o !== e_req) begin
        errors++; $display("FAIL req: got %b want %b (t=%0t)", req_o, e_req, $time);
      end
      if (req_o === 1'b1) req_seen++;
      p_open = m_open;
      p_req  = e_req;
      rd     = e_av && data_ack_i;
      if (rd) begin
        checks++;
        if (data_o !== mq[0]) begin
          errors++; $display("FAIL head_flit: got %h want %h (t=%0t)", data_o, mq[0], $time);
        end
        rd_log.push_back(data_o);
        flit = mq.pop_front();
        last = 0;
        if (idx == 0) begin
          idx = 1;
        end else if (idx == 1) begin
          rem = flit; idx = 2; last = (flit == '0);
        end else begin
          rem = rem - 1; last = (rem == '0);
        end
        if (last) begin m_open = 0; idx = 0; pkts_done++; end
      end
      if (rx_i && e_credit) begin mq.push_back(data_i); accepted++; end
      if (e_req && ack_h_i) begin m_open = 1; handshakes++; end
      p_cnt = cnt;
    end
  end

  task automatic wait_pkts(input int target, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk_i); #2;
      if (pkts_done >= target) begin ok = 1; break; end
    end
  endtask

  task automatic wait_log(input int target, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk_i); #2;
      if (rd_log.size() >= target) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    @(posedge clk_i); #2; rst_i = 1; tx_q.delete();
    @(posedge clk_i); #2;
    checks++;
    if (credit_o !== 1'b0) begin errors++; $display("FAIL reset_credit_low: got %b want 0", credit_o); end
    @(posedge clk_i); #2; rst_i = 0; #1;
    checks += 4;
    if (credit_o !== 1'b1) begin errors++; $display("FAIL reset_credit: got %b want 1", credit_o); end
    if (req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", req_o); end
    if (data_av_o !== 1'b0) begin errors++; $display("FAIL reset_data_av: got %b want 0", data_av_o); end
    if (sending_o !== 1'b0) begin errors++; $display("FAIL reset_sending: got %b want 0", sending_o); end
  endtask

  task automatic test_single();
    logic [FW-1:0] exp[$];
    int base = rd_log.size(), pk0 = pkts_done, hs0 = handshakes, rq0 = req_seen;
    bit ok;
    exp = '{32'h0011, 32'h0002, 32'hA, 32'hB};
    tx_q = exp;
    wait_pkts(pk0 + 1, 100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_timeout: done %0d want %0d", pkts_done, pk0 + 1); end
    checks++;
    if (sending_o !== 1'b0) begin errors++; $display("FAIL single_sending_drop: got %b want 0", sending_o); end
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (base + i >= rd_log.size() || rd_log[base+i] !== exp[i]) begin
        errors++; $display("FAIL single_flit%0d: got %h want %h", i, rd_log[base+i], exp[i]);
      end
    end
    checks += 2;
    if (handshakes - hs0 != 1) begin errors++; $display("FAIL single_handshakes: got %0d want 1", handshakes - hs0); end
    if (req_seen - rq0 != 1) begin errors++; $display("FAIL single_req_cycles: got %0d want 1", req_seen - rq0); end
  endtask

  task automatic test_full();
    logic [FW-1:0] exp[$];
    int base = rd_log.size(), pk0 = pkts_done, acc0 = accepted;
    bit ok;
    exp = '{32'h55, 32'h6, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6};
    auto_h = 0; d_pct = 0; tx_force = 1;
    tx_q = exp;
    tx_q.push_back(32'h99); tx_q.push_back(32'h98);
    repeat (12) @(posedge clk_i);
    #2;
    checks += 3;
    if (credit_o !== 1'b0) begin errors++; $display("FAIL full_credit: got %b want 0", credit_o); end
    if (accepted - acc0 != 8) begin errors++; $display("FAIL full_count: got %0d want 8", accepted - acc0); end
    if (req_o !== 1'b1) begin errors++; $display("FAIL full_req_held: got %b want 1", req_o); end
    tx_force = 0; ack_once = 1; auto_h = 1;
    wait_log(base + 1, 20, ok);
    checks += 2;
    if (!ok) begin errors++; $display("FAIL full_read_timeout: got %0d want %0d", rd_log.size(), base + 1); end
    if (credit_o !== 1'b1) begin errors++; $display("FAIL full_credit_return: got %b want 1", credit_o); end
    d_pct = 100;
    wait_pkts(pk0 + 1, 100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL full_drain_timeout: done %0d want %0d", pkts_done, pk0 + 1); end
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (base + i >= rd_log.size() || rd_log[base+i] !== exp[i]) begin
        errors++; $display("FAIL full_flit%0d: got %h want %h", i, rd_log[base+i], exp[i]);
      end
    end
  endtask

  task automatic test_zero_b2b();
    logic [FW-1:0] exp[$];
    int base = rd_log.size(), pk0 = pkts_done, hs0 = handshakes;
    bit ok;
    exp = '{32'h22, 32'h0, 32'h33, 32'h1, 32'hC};
    tx_q = exp;
    wait_pkts(pk0 + 2, 100, ok);
    checks += 3;
    if (!ok) begin errors++; $display("FAIL b2b_timeout: done %0d want %0d", pkts_done, pk0 + 2); end
    if (handshakes - hs0 != 2) begin errors++; $display("FAIL b2b_handshakes: got %0d want 2", handshakes - hs0); end
    if (sending_o !== 1'b0) begin errors++; $display("FAIL b2b_sending_drop: got %b want 0", sending_o); end
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (base + i >= rd_log.size() || rd_log[base+i] !== exp[i]) begin
        errors++; $display("FAIL b2b_flit%0d: got %h want %h", i, rd_log[base+i], exp[i]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [FW-1:0] exp[$];
    int base = rd_log.size(), pk0 = pkts_done;
    bit ok;
    for (int p = 0; p < 3; p++) begin
      exp.push_back(32'h100 + p);
      exp.push_back(32'd5);
      for (int j = 0; j < 5; j++) exp.push_back(32'h1000 * (p + 1) + j);
    end
    tx_q = exp;
    wait_pkts(pk0 + 3, 200, ok);
    checks += 2;
    if (!ok) begin errors++; $display("FAIL wrap_timeout: done %0d want %0d", pkts_done, pk0 + 3); end
    if (rd_log.size() - base != 21) begin errors++; $display("FAIL wrap_count: got %0d want 21", rd_log.size() - base); end
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (base + i >= rd_log.size() || rd_log[base+i] !== exp[i]) begin
        errors++; $display("FAIL wrap_flit%0d: got %h want %h", i, rd_log[base+i], exp[i]);
      end
    end
  endtask

  task automatic test_stall();
    logic [FW-1:0] exp[$];
    logic [FW-1:0] held;
    int base = rd_log.size(), pk0 = pkts_done;
    bit ok;
    exp = '{32'h44, 32'h6, 32'hD1, 32'hD2, 32'hD3, 32'hD4, 32'hD5, 32'hD6};
    for (int i = 0; i < 4; i++) tx_q.push_back(exp[i]);
    wait_log(base + 4, 100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL stall_first_timeout: got %0d want %0d", rd_log.size(), base + 4); end
    // Upstream gap: connection held with an empty buffer.
    for (int i = 0; i < 3; i++) begin
      checks += 2;
      if (data_av_o !== 1'b0) begin errors++; $display("FAIL stall_gap_av%0d: got %b want 0", i, data_av_o); end
      if (sending_o !== 1'b1) begin errors++; $display("FAIL stall_gap_sending%0d: got %b want 1", i, sending_o); end
      @(posedge clk_i); #2;
    end
    for (int i = 4; i < exp.size(); i++) tx_q.push_back(exp[i]);
    wait_log(base + 5, 50, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL stall_resume_timeout: got %0d want %0d", rd_log.size(), base + 5); end
    ack_low = 1;
    @(posedge clk_i); #2;
    held = data_o;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_i); #2;
      checks++;
      if (data_o !== held) begin errors++; $display("FAIL stall_data_stable%0d: got %h want %h", i, data_o, held); end
    end
    ack_low = 0;
    wait_pkts(pk0 + 1, 100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL stall_end_timeout: done %0d want %0d", pkts_done, pk0 + 1); end
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (base + i >= rd_log.size() || rd_log[base+i] !== exp[i]) begin
        errors++; $display("FAIL stall_flit%0d: got %h want %h", i, rd_log[base+i], exp[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [FW-1:0] exp[$];
    int base = rd_log.size(), pk0 = pkts_done, hs0 = handshakes, sz;
    bit ok;
    for (int p = 0; p < 8; p++) begin
      sz = $urandom_range(6);
      exp.push_back($urandom);
      exp.push_back(FW'(sz));
      for (int j = 0; j < sz; j++) exp.push_back($urandom);
    end
    tx_pct = 60; d_pct = 70; h_pct = 50; h_noise = 1;
    tx_q = exp;
    wait_pkts(pk0 + 8, 3000, ok);
    tx_pct = 100; d_pct = 100; h_pct = 100; h_noise = 0;
    checks += 2;
    if (!ok) begin errors++; $display("FAIL random_timeout: done %0d want %0d", pkts_done, pk0 + 8); end
    if (handshakes - hs0 != 8) begin errors++; $display("FAIL random_handshakes: got %0d want 8", handshakes - hs0); end
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (base + i >= rd_log.size() || rd_log[base+i] !== exp[i]) begin
        errors++; $display("FAIL random_flit%0d: got %h want %h", i, rd_log[base+i], exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [FW-1:0] exp[$];
    int base = rd_log.size(), pk0, base2;
    bit ok;
    tx_q = '{32'h77, 32'h5, 32'hE1, 32'hE2, 32'hE3, 32'hE4, 32'hE5};
    wait_log(base + 3, 100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rstmid_timeout: got %0d want %0d", rd_log.size(), base + 3); end
    rst_i = 1; tx_q.delete();
    @(posedge clk_i); #2; rst_i = 0; #1;
    checks += 5;
    if (rd_log.size() - base != 3) begin errors++; $display("FAIL rstmid_reads: got %0d want 3", rd_log.size() - base); end
    if (credit_o !== 1'b1) begin errors++; $display("FAIL rstmid_credit: got %b want 1", credit_o); end
    if (req_o !== 1'b0) begin errors++; $display("FAIL rstmid_req: got %b want 0", req_o); end
    if (data_av_o !== 1'b0) begin errors++; $display("FAIL rstmid_data_av: got %b want 0", data_av_o); end
    if (sending_o !== 1'b0) begin errors++; $display("FAIL rstmid_sending: got %b want 0", sending_o); end
    pk0 = pkts_done; base2 = rd_log.size();
    exp = '{32'h88, 32'h1, 32'hD};
    tx_q = exp;
    wait_pkts(pk0 + 1, 100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rstmid_new_timeout: done %0d want %0d", pkts_done, pk0 + 1); end
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (base2 + i >= rd_log.size() || rd_log[base2+i] !== exp[i]) begin
        errors++; $display("FAIL rstmid_flit%0d: got %h want %h", i, rd_log[base2+i], exp[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_zero_b2b();
    test_wrap();
    test_stall();
    test_random();
    test_reset_mid();
    repeat (2) @(posedge clk_i);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
